dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Initiator side of the word-only data-memory port, driving dbg_dmem from the MEM stage.
//  Converts byte/halfword/word loads and stores into aligned word accesses.
//  Sub-word stores become a read-modify-write: one read, then a merged word write.
//  Misaligned accesses are detected and return an error response with no memory access.
// PARAMETERS
//  W          `WORD_WIDTH (32)  data/address width; byte-lane logic fixed for W=32
//  BIG_ENDIAN 1                 1: byte offset 0 = bits[31:24]; 0: offset 0 = bits[7:0]
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst            in   1   reset, synchronous, active-high
//  req_valid      in   1   EX/MEM request valid
//  req_ready      out  1   request accepted when req_valid&&req_ready
//  req_op         in   3   `MEM_LB/LBU/LH/LHU/LW/SB/SH/SW
//  req_addr       in   W   byte address
//  req_wdata      in   W   store data, right-justified for SB/SH
//  resp_valid     out  1   response valid; held until resp_ready
//  resp_ready     in   1   WB consumer ready
//  resp_rdata     out  W   load result, extended per op; 0 for stores/errors
//  resp_err       out  1   1 = misaligned access, nothing done
//  mem_read_en    out  1   to dmem read_en
//  mem_read_addr  out  W   to dmem read_addr, always {addr[W-1:2],2'b00}
//  mem_read_data  in   W   from dmem, combinational same-cycle
//  mem_write_en   out  1   to dmem write_en
//  mem_write_addr out  W   to dmem write_addr, word aligned
//  mem_write_data out  W   to dmem write_data, full merged word
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0 during rst, 1 the cycle after; resp_valid=0, resp_err=0,
//   resp_rdata=0, mem_*_en=0, mem_*_addr=0, mem_write_data=0. Reset mid-op aborts: no write issued.
//  FSM states IDLE, LOAD, RMW_RD, WRITE, RESP. req_ready=1 only in IDLE.
//  IDLE: on accept, latch op/addr/wdata. Misaligned (LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0)
//   -> RESP with resp_err=1, rdata=0. Loads -> LOAD. SW -> WRITE, merged=wdata. SB/SH -> RMW_RD.
//  LOAD: mem_read_en=1; capture lane of mem_read_data into resp_rdata: LB/LH sign-extend,
//   LBU/LHU zero-extend, LW whole word -> RESP.
//  RMW_RD: mem_read_en=1; merged = read word with addressed byte/half lanes replaced by
//   wdata[7:0]/wdata[15:0], other lanes untouched -> WRITE.
//  WRITE: mem_write_en=1 for exactly one cycle, address aligned, data=merged -> RESP.
//  RESP: resp_valid=1, outputs stable until resp_ready; on resp_ready -> IDLE. Next accept is
//   the cycle after (no same-cycle turnaround).
//  Accept in cycle 0: err resp cycle 1; LW/LBx/LHx and SW resp cycle 2; SB/SH resp cycle 3.
//  Read and write never asserted in the same cycle, so the dmem forward path is never used.
//  mem_read_en/mem_write_en are 0 in every state not listed above; addrs hold last value.
//  Lane select with BIG_ENDIAN=1: byte k at bits[31-8k -: 8]; halfword 0=[31:16], 2=[15:0].
//  Back-pressure: resp_ready low holds RESP indefinitely; no new request accepted.
// STRUCTURE
//  defines.v holds `WORD_WIDTH, `ZERO_WORD, `MEM_OP_WIDTH and the eight `MEM_* op codes
//   (LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7), plus the FSM state encodings.
//  One combinational sub-module, mem_lane_align: extract+extend (load) and merge (store)
//   from op, addr[1:0], word, wdata. The FSM stays in dmem_access_ctrl.
// TESTING (bench pairs with dbg_dmem; mem word 0x4 preloaded 0x8899AABB, BIG_ENDIAN=1)
//  LB addr 0x4 -> resp cycle 2, rdata=0xFFFFFF88; LBU addr 0x7 -> rdata=0x000000BB.
//  LH addr 0x6 -> rdata=0xFFFFAABB; LHU addr 0x4 -> rdata=0x00008899; LW addr 0x4 -> 0x8899AABB.
//  SB addr 0x5 wdata 0x12345677 -> one read, one write of 0x8877AABB, resp cycle 3;
//   then LW addr 0x4 -> 0x8877AABB.
//  SW addr 0x4 wdata 0xDEADBEEF -> no read, one write, resp cycle 2.
//  LW addr 0x6, SH addr 0x5 -> resp_err=1 cycle 1, rdata=0, no mem_*_en pulse.
//  resp_ready low 5 cycles -> resp_valid/rdata stable, req_ready=0.
//  rst asserted during WRITE of SB -> mem_write_en=0 that cycle, memory word unchanged.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared op codes, FSM state encoding and decode helpers for the data-memory
// access controller.
package dmem_access_ctrl_pkg;

  localparam int WORD_WIDTH   = 32;
  localparam int MEM_OP_WIDTH = 3;

  localparam logic [MEM_OP_WIDTH-1:0] MEM_LB  = 3'd0;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LBU = 3'd1;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LH  = 3'd2;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LHU = 3'd3;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LW  = 3'd4;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SB  = 3'd5;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SH  = 3'd6;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SW  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  function automatic logic is_misaligned(input logic [MEM_OP_WIDTH-1:0] op,
                                         input logic [1:0] off);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return off[0];
      MEM_LW, MEM_SW:          return |off;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [MEM_OP_WIDTH-1:0] op);
    return op <= MEM_LW;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_mem_lane_align.sv
// Byte/halfword lane steering: extracts and extends a load lane, and merges
// store data into a read word for read-modify-write.
module mem_lane_align
  import dmem_access_ctrl_pkg::*;
#(
  parameter int W          = WORD_WIDTH,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [MEM_OP_WIDTH-1:0] op,
  input  logic [1:0]              off,
  input  logic [W-1:0]            word,
  input  logic [W-1:0]            wdata,
  output logic [W-1:0]            load_data,
  output logic [W-1:0]            merged
);

  logic         half;
  logic [4:0]   sh;
  logic [W-1:0] mask;
  logic [W-1:0] lane;

  always_comb begin
    half = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
    // Big-endian puts offset 0 in the top lane, so the shift counts down.
    if (BIG_ENDIAN) sh = half ? {~off[1], 4'b0000} : {~off, 3'b000};
    else            sh = half ? { off[1], 4'b0000} : { off, 3'b000};
    mask = half ? W'(16'hFFFF) : W'(8'hFF);
    lane = (word >> sh) & mask;
    case (op)
      MEM_LB:           load_data = {{(W-8){lane[7]}}, lane[7:0]};
      MEM_LH:           load_data = {{(W-16){lane[15]}}, lane[15:0]};
      MEM_LBU, MEM_LHU: load_data = lane;
      default:          load_data = word;
    endcase
    merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Initiator for a word-only data memory: turns sub-word loads/stores into
// aligned word reads, writes and read-modify-writes, flagging misalignment.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int W          = WORD_WIDTH,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [MEM_OP_WIDTH-1:0] req_op,
  input  logic [W-1:0]            req_addr,
  input  logic [W-1:0]            req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [W-1:0]            resp_rdata,
  output logic                    resp_err,
  output logic                    mem_read_en,
  output logic [W-1:0]            mem_read_addr,
  input  logic [W-1:0]            mem_read_data,
  output logic                    mem_write_en,
  output logic [W-1:0]            mem_write_addr,
  output logic [W-1:0]            mem_write_data
);

  state_e                  state_q, state_d;
  logic [MEM_OP_WIDTH-1:0] op_q, op_d;
  logic [W-1:0]            addr_q, addr_d;
  logic [W-1:0]            wdata_q, wdata_d;
  logic [W-1:0]            merged_q, merged_d;
  logic [W-1:0]            rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [W-1:0]            lane_load;
  logic [W-1:0]            lane_merged;

  mem_lane_align #(.W(W), .BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .op        (op_q),
    .off       (addr_q[1:0]),
    .word      (mem_read_data),
    .wdata     (wdata_q),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  // Enables are gated by rst so a reset landing mid-operation never writes.
  assign req_ready      = (state_q == ST_IDLE) && !rst;
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_read_en    = ((state_q == ST_LOAD) || (state_q == ST_RMW_RD)) && !rst;
  assign mem_write_en   = (state_q == ST_WRITE) && !rst;
  assign mem_read_addr  = {addr_q[W-1:2], 2'b00};
  assign mem_write_addr = {addr_q[W-1:2], 2'b00};
  assign mem_write_data = merged_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (is_misaligned(req_op, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (is_load(req_op)) begin
            state_d = ST_LOAD;
          end else if (req_op == MEM_SW) begin
            merged_d = req_wdata;
            state_d  = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = lane_load;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        merged_d = lane_merged;
        state_d  = ST_WRITE;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule
